msrv32_dmem_ahb_slave: RTL and testbench

//  AHB-Lite data-memory responder: the slave end of the core's data port.
//  - Sits between the core's store/load interface and a word-addressed on-chip SRAM array.
//  - Accepts pipelined address/data phases, inserts programmable wait states, applies byte-masked writes.
//  - Returns full read words and signals a two-cycle ERROR response for out-of-range addresses.

---
 rtl/msrv32_dmem_ahb_slave.sv | 128 ++++++++++++
 tb/tb_msrv32_dmem_ahb_slave.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/msrv32_dmem_ahb_slave.sv
// AHB-Lite data-memory slave. It has a word-addressed SRAM array, a programmable wait-state count,
// byte-masked writes and a two-cycle ERROR response for addresses outside the array.
//
//   state | meaning
//   IDLE  | no data phase in progress, ready for an address phase
//   WAIT  | in-range data phase stalled, counting down wait states
//   DATA  | final data-phase cycle, write commits / read data presented
//   ERR1  | first ERROR cycle (hready low)
//   ERR2  | second ERROR cycle (hready high), next address phase accepted
module msrv32_dmem_ahb_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [1:0]  ms_riscv32_mp_htrans_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  output logic        ms_riscv32_mp_hready_out,
  output logic        ms_riscv32_mp_hresp_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [AW-1:0]  idx_q;
  logic           wr_q;
  logic [31:0]    mem [DEPTH];

  logic [31:0]    off;
  logic           in_range;
  logic [AW-1:0]  new_idx;
  logic           addr_phase;
  logic [AW-1:0]  rd_idx;
  logic           rd_is_read;
  logic           load_rd;
  logic           commit;
  logic [31:0]    rd_word;

  assign off      = ms_riscv32_mp_dmaddr_in - BASE_ADDR;
  assign in_range = {1'b0, off} < SPAN;
  assign new_idx  = off[AW+1:2];

  always_comb begin
    ms_riscv32_mp_hready_out = 1'b1;
    ms_riscv32_mp_hresp_out  = 1'b0;
    case (state)
      WAIT:    ms_riscv32_mp_hready_out = 1'b0;
      ERR1:    begin ms_riscv32_mp_hready_out = 1'b0; ms_riscv32_mp_hresp_out = 1'b1; end
      ERR2:    ms_riscv32_mp_hresp_out = 1'b1;
      default: ;
    endcase
  end

  assign addr_phase = ms_riscv32_mp_hready_out && ms_riscv32_mp_htrans_in[1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT: begin
        if (cnt == 4'd0) state_nxt = DATA;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ERR1: state_nxt = ERR2;
      default: begin
        if (!addr_phase)          state_nxt = IDLE;
        else if (!in_range)       state_nxt = ERR1;
        else if (WAIT_STATES > 0) begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(WAIT_STATES - 1);
        end
        else                      state_nxt = DATA;
      end
    endcase
  end

  // Entering DATA from WAIT uses the captured transfer, otherwise the live address phase.
  assign rd_idx     = (state == WAIT) ? idx_q : new_idx;
  assign rd_is_read = (state == WAIT) ? !wr_q : !ms_riscv32_mp_dmwr_req_in;
  assign load_rd    = (state_nxt == DATA) && rd_is_read;
  assign commit     = (state == DATA) && wr_q;

  always_comb begin
    rd_word = mem[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int i = 0; i < 4; i++)
        if (ms_riscv32_mp_dmwr_mask_in[i]) rd_word[8*i +: 8] = ms_riscv32_mp_dmdata_in[8*i +: 8];
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state                    <= IDLE;
      cnt                      <= 4'd0;
      idx_q                    <= '0;
      wr_q                     <= 1'b0;
      ms_riscv32_mp_dmdata_out <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (addr_phase) begin
        idx_q <= new_idx;
        wr_q  <= ms_riscv32_mp_dmwr_req_in && in_range;
      end else if (state == DATA) begin
        wr_q  <= 1'b0;
      end
      if (load_rd) ms_riscv32_mp_dmdata_out <= rd_word;
    end
  end

  // The array has no reset; its contents survive reset.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (commit) begin
      for (int i = 0; i < 4; i++)
        if (ms_riscv32_mp_dmwr_mask_in[i]) mem[idx_q][8*i +: 8] <= ms_riscv32_mp_dmdata_in[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_msrv32_dmem_ahb_slave.sv
// Directed bench for msrv32_dmem_ahb_slave. Instance 0 has zero wait states and instance 1 has two.
module tb_msrv32_dmem_ahb_slave;

  logic        clk;
  logic        rst   [2];
  logic [31:0] addr  [2];
  logic [1:0]  trans [2];
  logic        wr    [2];
  logic [31:0] wdata [2];
  logic [3:0]  mask  [2];
  logic        hready[2];
  logic        hresp [2];
  logic [31:0] rdata [2];

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

  msrv32_dmem_ahb_slave #(.DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .ms_riscv32_mp_clk_in      (clk),
    .ms_riscv32_mp_rst_in      (rst[0]),
    .ms_riscv32_mp_dmaddr_in   (addr[0]),
    .ms_riscv32_mp_htrans_in   (trans[0]),
    .ms_riscv32_mp_dmwr_req_in (wr[0]),
    .ms_riscv32_mp_dmdata_in   (wdata[0]),
    .ms_riscv32_mp_dmwr_mask_in(mask[0]),
    .ms_riscv32_mp_hready_out  (hready[0]),
    .ms_riscv32_mp_hresp_out   (hresp[0]),
    .ms_riscv32_mp_dmdata_out  (rdata[0])
  );

  msrv32_dmem_ahb_slave #(.DEPTH(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dutw (
    .ms_riscv32_mp_clk_in      (clk),
    .ms_riscv32_mp_rst_in      (rst[1]),
    .ms_riscv32_mp_dmaddr_in   (addr[1]),
    .ms_riscv32_mp_htrans_in   (trans[1]),
    .ms_riscv32_mp_dmwr_req_in (wr[1]),
    .ms_riscv32_mp_dmdata_in   (wdata[1]),
    .ms_riscv32_mp_dmwr_mask_in(mask[1]),
    .ms_riscv32_mp_hready_out  (hready[1]),
    .ms_riscv32_mp_hresp_out   (hresp[1]),
    .ms_riscv32_mp_dmdata_out  (rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input int s, input logic [1:0] t, input logic [31:0] a, input logic w);
    trans[s] = t;
    addr[s]  = a;
    wr[s]    = w;
  endtask

  task automatic wdat(input int s, input logic [31:0] d, input logic [3:0] m);
    wdata[s] = d;
    mask[s]  = m;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b0;
      bus(s, T_IDLE, 32'h0, 1'b0);
      wdat(s, 32'h0, 4'h0);
    end
    #1;
    chk("rst_hready", {31'd0, hready[0]}, 32'd1);
    chk("rst_hresp",  {31'd0, hresp[0]},  32'd0);
    chk("rst_rdata",  rdata[0], 32'd0);
    tick();
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    tick();

    // ---- zero-wait instance ----
    bus(0, T_NS, 32'h0, 1'b1); tick();
    wdat(0, 32'h0102_0304, 4'hF); bus(0, T_IDLE, 32'h0, 1'b0); tick();

    bus(0, T_NS, 32'h10, 1'b1); tick();
    chk("t2_hready_wr", {31'd0, hready[0]}, 32'd1);
    wdat(0, 32'hDEAD_BEEF, 4'hF); bus(0, T_NS, 32'h10, 1'b0); tick();
    chk("t2_hready_rd", {31'd0, hready[0]}, 32'd1);
    chk("t2_bypass", rdata[0], 32'hDEAD_BEEF);
    bus(0, T_IDLE, 32'h0, 1'b0); tick();

    bus(0, T_NS, 32'h20, 1'b1); tick();
    wdat(0, 32'h1122_3344, 4'hF); bus(0, T_NS, 32'h20, 1'b1); tick();
    wdat(0, 32'hAABB_CCDD, 4'h5); bus(0, T_NS, 32'h20, 1'b0); tick();
    chk("t3_bypass_merge", rdata[0], 32'h11BB_33DD);
    bus(0, T_IDLE, 32'h0, 1'b0); tick();
    bus(0, T_NS, 32'h20, 1'b0); tick();
    chk("t3_readback", rdata[0], 32'h11BB_33DD);
    bus(0, T_IDLE, 32'h0, 1'b0); tick();

    bus(0, T_NS, 32'h10, 1'b1); tick();
    wdat(0, 32'h0, 4'h0); bus(0, T_IDLE, 32'h0, 1'b0); tick();
    bus(0, T_NS, 32'h10, 1'b0); tick();
    chk("mask0_noop", rdata[0], 32'hDEAD_BEEF);
    bus(0, T_IDLE, 32'h0, 1'b0); tick();

    bus(0, T_NS, 32'hFFC, 1'b1); tick();
    wdat(0, 32'h5A5A_0FFC, 4'hF); bus(0, T_IDLE, 32'h0, 1'b0); tick();
    bus(0, T_NS, 32'hFFC, 1'b0); tick();
    chk("last_word", rdata[0], 32'h5A5A_0FFC);
    bus(0, T_IDLE, 32'h0, 1'b0); tick();

    bus(0, T_NS, 32'h1000, 1'b0); tick();
    chk("t5_err1_hready", {31'd0, hready[0]}, 32'd0);
    chk("t5_err1_hresp",  {31'd0, hresp[0]},  32'd1);
    bus(0, T_IDLE, 32'h0, 1'b0); tick();
    chk("t5_err2_hready", {31'd0, hready[0]}, 32'd1);
    chk("t5_err2_hresp",  {31'd0, hresp[0]},  32'd1);
    chk("t5_rdata_held",  rdata[0], 32'h5A5A_0FFC);
    tick();
    chk("t5_okay_after", {31'd0, hresp[0]}, 32'd0);

    bus(0, T_NS, 32'h1000, 1'b1); tick();
    wdat(0, 32'hFFFF_FFFF, 4'hF); bus(0, T_IDLE, 32'h0, 1'b0); tick();
    tick();
    bus(0, T_NS, 32'h0, 1'b0); tick();
    chk("t5_mem0_intact", rdata[0], 32'h0102_0304);
    bus(0, T_IDLE, 32'h0, 1'b0); tick();

    bus(0, T_NS, 32'h10, 1'b0); tick();
    chk("t6_first_read", rdata[0], 32'hDEAD_BEEF);
    bus(0, T_BUSY, 32'h14, 1'b0); tick();
    chk("t6_busy_hready", {31'd0, hready[0]}, 32'd1);
    chk("t6_busy_hresp",  {31'd0, hresp[0]},  32'd0);
    chk("t6_busy_hold",   rdata[0], 32'hDEAD_BEEF);
    bus(0, T_SEQ, 32'h20, 1'b0); tick();
    chk("t6_second_read", rdata[0], 32'h11BB_33DD);
    bus(0, T_IDLE, 32'h0, 1'b0); tick();

    // ---- two-wait-state instance ----
    bus(1, T_NS, 32'h4, 1'b1); tick();
    chk("w_wr_wait1", {31'd0, hready[1]}, 32'd0);
    wdat(1, 32'hCAFE_F00D, 4'hF); bus(1, T_IDLE, 32'h0, 1'b0); tick();
    chk("w_wr_wait2", {31'd0, hready[1]}, 32'd0);
    tick();
    chk("w_wr_data", {31'd0, hready[1]}, 32'd1);
    tick();

    bus(1, T_NS, 32'h4, 1'b0); tick();
    chk("t4_wait1", {31'd0, hready[1]}, 32'd0);
    bus(1, T_IDLE, 32'h0, 1'b0); tick();
    chk("t4_wait2", {31'd0, hready[1]}, 32'd0);
    tick();
    chk("t4_data_hready", {31'd0, hready[1]}, 32'd1);
    chk("t4_data", rdata[1], 32'hCAFE_F00D);
    bus(1, T_NS, 32'h4, 1'b0); tick();
    chk("t4_pipelined_accept", {31'd0, hready[1]}, 32'd0);
    bus(1, T_IDLE, 32'h0, 1'b0); tick();
    tick();
    chk("t4_second_data", rdata[1], 32'hCAFE_F00D);
    tick();

    bus(1, T_NS, 32'h2000, 1'b0); tick();
    chk("w_err1_hresp", {31'd0, hresp[1]}, 32'd1);
    bus(1, T_IDLE, 32'h0, 1'b0); tick();
    chk("w_err2_nowait", {30'd0, hready[1], hresp[1]}, 32'd3);
    tick();

    bus(1, T_NS, 32'h4, 1'b0); tick();
    chk("t1_in_wait", {31'd0, hready[1]}, 32'd0);
    rst[1] = 1'b0;
    #1;
    chk("t1_rst_hready", {31'd0, hready[1]}, 32'd1);
    chk("t1_rst_hresp",  {31'd0, hresp[1]},  32'd0);
    chk("t1_rst_rdata",  rdata[1], 32'd0);
    bus(1, T_IDLE, 32'h0, 1'b0); tick();
    rst[1] = 1'b1; tick();
    bus(1, T_NS, 32'h4, 1'b0); tick();
    bus(1, T_IDLE, 32'h0, 1'b0); tick();
    tick();
    chk("t1_array_kept", rdata[1], 32'hCAFE_F00D);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
